// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H palette-index sprite from ROM into the
// frame buffer at (pos_x, pos_y), with horizontal mirroring, colour-key skip and clipping.
module sprite_blitter #(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int IDX_W  = 4,
  parameter int TRANSP = 0
) (
  input  logic                               vga_clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [9:0]                         pos_x,
  input  logic [9:0]                         pos_y,
  input  logic                               flip_x,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(SPR_W*SPR_H)-1:0]     rom_address,
  input  logic [IDX_W-1:0]                   rom_q,
  output logic                               fb_we,
  output logic [16:0]                        fb_addr,
  output logic [IDX_W-1:0]                   fb_data
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = $clog2(SPR_H);

  localparam logic [SX_W-1:0]  SX_MAX   = '1;
  localparam logic [SY_W-1:0]  SY_MAX   = '1;
  localparam logic [10:0]      FB_W11   = 11'(FB_W);
  localparam logic [10:0]      FB_H11   = 11'(FB_H);
  localparam logic [16:0]      FB_W17   = 17'(FB_W);
  localparam logic [IDX_W-1:0] TRANSP_I = IDX_W'(TRANSP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic [9:0]      pos_x_q;
  logic [9:0]      pos_y_q;
  logic            flip_q;

  logic            p_valid;
  logic            p_in_range;
  logic [16:0]     addr_q;

  logic [10:0]     dx;
  logic [10:0]     dy;
  logic [16:0]     addr_next;

  // SPR_W is a power of two, so SPR_W-1-sx is simply the bitwise complement of sx.
  assign rom_address = {sy, (flip_q ? ~sx : sx)};

  assign dx        = {1'b0, pos_x_q} + 11'(sx);
  assign dy        = {1'b0, pos_y_q} + 11'(sy);
  assign addr_next = 17'(dy) * FB_W17 + 17'(dx);

  // The ROM answers one cycle after the address, i.e. in the same cycle as the
  // registered pipeline stage, so the key test and data pass straight from rom_q.
  assign fb_we   = p_valid & p_in_range & (rom_q != TRANSP_I);
  assign fb_data = p_valid ? rom_q : '0;
  assign fb_addr = addr_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sx         <= '0;
      sy         <= '0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      flip_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      p_valid    <= 1'b0;
      p_in_range <= 1'b0;
      addr_q     <= '0;
    end else begin
      p_valid    <= (state == RUN);
      p_in_range <= (dx < FB_W11) && (dy < FB_H11);
      addr_q     <= addr_next;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
            flip_q  <= flip_x;
            sx      <= '0;
            sy      <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sx <= sx + 1'b1;
          if (sx == SX_MAX) begin
            sy <= sy + 1'b1;
            if (sy == SY_MAX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
